// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Request/acknowledge bus between the memory-access stage and data memory.
//
// Signals:
//   mem_req    request valid (unit -> memory)
//   mem_we     request is a write (unit -> memory)
//   mem_addr   32-bit word-aligned address (unit -> memory)
//   mem_wdata  32-bit write data (unit -> memory)
//   mem_rdata  32-bit read data, valid while mem_ack is high (memory -> unit)
//   mem_ack    request completed (memory -> unit)
//
// Modports:
//   master  memory-access unit side
//   slave   data memory side
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-access stage between execute and writeback. Accepts one load or
// store from the pipeline, runs a request/acknowledge transaction with data
// memory, and for loads captures the returned word as mem_read. The pipeline
// is stalled while the transaction is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   -> an ACCESS that sees no mem_ack for TIMEOUT_CYCLES cycles is
//                abandoned through ABORT (err and done pulse, mem_read = 0).
//   Undefined -> ACCESS waits indefinitely and err is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles without ack before abort (1..255)
//
// Ports:
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   start       pipeline presents a memory op
//   is_load     op is a load (priority over is_store)
//   is_store    op is a store
//   address     byte address from the ALU
//   store_data  register data for stores
//   mem         data-memory bus (mem_access_unit_if.master)
//   mem_read    captured load data for the writeback selector
//   stall       pipeline must hold (combinational)
//   done        one-cycle completion pulse
//   err         one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic                      is_load,
   input  logic                      is_store,
   input  logic [31:0]               address,
   input  logic [31:0]               store_data,
   mem_access_unit_if.master         mem,
   output logic [31:0]               mem_read,
   output logic                      stall,
   output logic                      done,
   output logic                      err
);

`ifdef MEM_TIMEOUT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ABORT  = 2'd3
   } state_t;

   // Abort fires on the TIMEOUT_CYCLES-th ACCESS cycle without ack; cnt holds
   // the number of ack-less cycles already seen, so compare against limit-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt;
   logic       err_r;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;
`endif

   state_t      state;
   logic        req_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] read_r;
   logic        done_r;
   logic        op_valid;

   // The two low address bits are dropped (word access, no alignment trap);
   // TIMEOUT_CYCLES is only consumed when the timeout feature is built in.
   logic unused_ok;
   assign unused_ok = ^{1'b0, address[1:0], 8'(TIMEOUT_CYCLES)};

   assign op_valid = start & (is_load | is_store);

   // Combinational so the pipeline freezes in the same cycle as start.
   // Gated by rstn so stall reads 0 while reset is held.
   assign stall = rstn & (((state == ST_IDLE) & op_valid) | (state == ST_ACCESS));

   assign mem.mem_req   = req_r;
   assign mem.mem_we    = we_r;
   assign mem.mem_addr  = addr_r;
   assign mem.mem_wdata = wdata_r;
   assign mem_read      = read_r;
   assign done          = done_r;

`ifdef MEM_TIMEOUT_EN
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= 32'h0;
         wdata_r <= 32'h0;
         read_r  <= 32'h0;
         done_r  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt     <= 8'h0;
         err_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         err_r  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // Ack while idle is ignored; start without an op bit is ignored.
               if (op_valid) begin
                  addr_r  <= {address[31:2], 2'b00};
                  wdata_r <= store_data;
                  we_r    <= ~is_load;
                  req_r   <= 1'b1;
                  state   <= ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
                  cnt     <= 8'h0;
`endif
               end
            end

            ST_ACCESS: begin
               // Ack has priority over a timeout reached in the same cycle.
               if (mem.mem_ack) begin
                  if (!we_r) begin
                     read_r <= mem.mem_rdata;
                  end
                  req_r  <= 1'b0;
                  done_r <= 1'b1;
                  state  <= ST_DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  req_r  <= 1'b0;
                  done_r <= 1'b1;
                  err_r  <= 1'b1;
                  read_r <= 32'h0;
                  state  <= ST_ABORT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end

            // A start offered here is not taken; the pipeline re-presents it.
            ST_DONE: state <= ST_IDLE;

`ifdef MEM_TIMEOUT_EN
            ST_ABORT: state <= ST_IDLE;
`endif

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. Expected behaviour is described
// per transaction: an accepted op holds the bus for (wait+1) cycles, then a
// one-cycle done, and mem_read follows the last completed load.
// With MEM_TIMEOUT_EN defined the timeout path is exercised as well.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
   logic        clk;
   logic        rstn;
   logic        start;
   logic        is_load;
   logic        is_store;
   logic [31:0] address;
   logic [31:0] store_data;
   logic [31:0] mem_read;
   logic        stall;
   logic        done;
   logic        err;

   logic [31:0] exp_read;
   int          passed;
   int          total;

   mem_access_unit_if mem_if ();

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .is_load    (is_load),
      .is_store   (is_store),
      .address    (address),
      .store_data (store_data),
      .mem        (mem_if),
      .mem_read   (mem_read),
      .stall      (stall),
      .done       (done),
      .err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with spurious acks and op-less starts: nothing may happen.
   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         start            = 1'($urandom_range(0, 1));
         is_load          = 1'b0;
         is_store         = 1'b0;
         address          = $urandom;
         store_data       = $urandom;
         mem_if.mem_ack   = 1'($urandom_range(0, 1));
         mem_if.mem_rdata = $urandom;
         @(negedge clk);
         chk("idle_req", {31'h0, mem_if.mem_req}, 32'h0);
         chk("idle_done", {31'h0, done}, 32'h0);
         chk("idle_stall", {31'h0, stall}, 32'h0);
         chk("idle_read", mem_read, exp_read);
         next_cycle();
      end
      mem_if.mem_ack = 1'b0;
      start          = 1'b0;
   endtask

   // One complete op: start at cycle 0, ack after nwait ack-less ACCESS cycles.
   task automatic run_op(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int nwait);
      logic [31:0] waddr;
      logic        we_exp;
      waddr  = {a[31:2], 2'b00};
      we_exp = ~ld;

      start          = 1'b1;
      is_load        = ld;
      is_store       = st;
      address        = a;
      store_data     = wd;
      mem_if.mem_ack = 1'b0;
      @(negedge clk);
      chk("start_stall", {31'h0, stall}, 32'h1);
      chk("start_req", {31'h0, mem_if.mem_req}, 32'h0);
      next_cycle();

      // Scramble the pipeline inputs: the bus must keep the latched values.
      start      = 1'b0;
      is_load    = 1'($urandom_range(0, 1));
      is_store   = 1'($urandom_range(0, 1));
      address    = $urandom;
      store_data = $urandom;
      for (int i = 0; i <= nwait; i++) begin
         mem_if.mem_ack   = (i == nwait);
         mem_if.mem_rdata = (i == nwait) ? rd : $urandom;
         @(negedge clk);
         chk("acc_req", {31'h0, mem_if.mem_req}, 32'h1);
         chk("acc_we", {31'h0, mem_if.mem_we}, {31'h0, we_exp});
         chk("acc_addr", mem_if.mem_addr, waddr);
         if (!ld) chk("acc_wdata", mem_if.mem_wdata, wd);
         chk("acc_stall", {31'h0, stall}, 32'h1);
         chk("acc_done", {31'h0, done}, 32'h0);
         next_cycle();
      end
      if (ld) exp_read = rd;

      // DONE cycle: a fresh start offered here must not be accepted.
      mem_if.mem_ack = 1'b0;
      start          = 1'b1;
      is_load        = 1'b1;
      is_store       = 1'b0;
      @(negedge clk);
      chk("done_pulse", {31'h0, done}, 32'h1);
      chk("done_err", {31'h0, err}, 32'h0);
      chk("done_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("done_stall", {31'h0, stall}, 32'h0);
      chk("done_read", mem_read, exp_read);
      next_cycle();

      start = 1'b0;
      @(negedge clk);
      chk("post_req", {31'h0, mem_if.mem_req}, 32'h0);
      chk("post_done", {31'h0, done}, 32'h0);
      chk("post_read", mem_read, exp_read);
      next_cycle();
   endtask

   initial begin
      passed           = 0;
      total            = 0;
      exp_read         = 32'h0;
      rstn             = 1'b1;
      start            = 1'b0;
      is_load          = 1'b0;
      is_store         = 1'b0;
      address          = 32'h0;
      store_data       = 32'h0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'h0;
      #2 rstn = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) begin
         start            = 1'($urandom_range(0, 1));
         is_load          = 1'($urandom_range(0, 1));
         is_store         = 1'($urandom_range(0, 1));
         address          = $urandom;
         store_data       = $urandom;
         mem_if.mem_ack   = 1'($urandom_range(0, 1));
         mem_if.mem_rdata = $urandom;
         @(negedge clk);
         chk("rst_req", {31'h0, mem_if.mem_req}, 32'h0);
         chk("rst_we", {31'h0, mem_if.mem_we}, 32'h0);
         chk("rst_addr", mem_if.mem_addr, 32'h0);
         chk("rst_wdata", mem_if.mem_wdata, 32'h0);
         chk("rst_read", mem_read, 32'h0);
         chk("rst_done", {31'h0, done}, 32'h0);
         chk("rst_err", {31'h0, err}, 32'h0);
         chk("rst_stall", {31'h0, stall}, 32'h0);
         next_cycle();
      end
      start          = 1'b0;
      mem_if.mem_ack = 1'b0;
      rstn           = 1'b1;
      next_cycle();

      // Single load, ack in cycle 3.
      run_op(1'b1, 1'b0, 32'h0000_1007, 32'h0, 32'hCAFE_F00D, 2);
      // Store, ack in cycle 1; mem_read keeps the load value.
      run_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 0);
      // Both op bits set: treated as a load.
      run_op(1'b1, 1'b1, 32'h0000_0443, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1);

      // Spurious ack in IDLE and op-less start.
      idle_chk(4);

      // Reset mid-op at cycle 2 of an unacked load.
      start    = 1'b1;
      is_load  = 1'b1;
      is_store = 1'b0;
      address  = 32'h0000_0100;
      next_cycle();
      start = 1'b0;
      next_cycle();
      chk("mid_req_before", {31'h0, mem_if.mem_req}, 32'h1);
      rstn = 1'b0;
      #1;
      chk("mid_req_async", {31'h0, mem_if.mem_req}, 32'h0);
      chk("mid_stall_async", {31'h0, stall}, 32'h0);
      exp_read       = 32'h0;
      mem_if.mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_done", {31'h0, done}, 32'h0);
         chk("mid_read", mem_read, 32'h0);
         next_cycle();
      end
      mem_if.mem_ack = 1'b0;
      rstn           = 1'b1;
      idle_chk(1);
      run_op(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h5A5A_A5A5, 1);

`ifdef MEM_TIMEOUT_EN
      // Load with no ack: four ACCESS cycles, then abort.
      start          = 1'b1;
      is_load        = 1'b1;
      is_store       = 1'b0;
      address        = 32'h0000_0200;
      mem_if.mem_ack = 1'b0;
      next_cycle();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("to_req", {31'h0, mem_if.mem_req}, 32'h1);
         chk("to_err_early", {31'h0, err}, 32'h0);
         next_cycle();
      end
      exp_read = 32'h0;
      @(negedge clk);
      chk("to_err", {31'h0, err}, 32'h1);
      chk("to_done", {31'h0, done}, 32'h1);
      chk("to_req_drop", {31'h0, mem_if.mem_req}, 32'h0);
      chk("to_read", mem_read, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("to_err_clear", {31'h0, err}, 32'h0);
      next_cycle();
      // Ack on the 4th ACCESS cycle wins over the timeout.
      run_op(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h7777_1111, 3);
`endif

      // Randomised ops against the transaction-level expectations.
      for (int n = 0; n < 40; n++) begin
         logic ld;
         logic st;
         ld = 1'($urandom_range(0, 1));
         st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
         run_op(ld, st, $urandom, $urandom, $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) idle_chk(1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage between execute and writeback. Takes one load or store from the pipeline and runs a request/acknowledge transaction with data memory. For loads it captures the returned word and presents it as `mem_read` to the writeback data selector. It stalls the pipeline for the duration of the transaction.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum `ACCESS` cycles without `mem_ack` before abort. Used only when `MEM_TIMEOUT_EN` is defined. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pipeline presents a memory op this cycle.
- `is_load`  in  1  the op is a load. Sampled with `start`.
- `is_store`  in  1  the op is a store. Sampled with `start`. `is_load` takes priority if both are set.
- `address`  in  32  byte address from the ALU.
- `store_data`  in  32  register data for stores.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data. Valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  memory completes the request.
- `mem_read`  out  32  captured load data, fed to the writeback selector.
- `stall`  out  1  pipeline must hold.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle timeout pulse. Tied to 0 when `MEM_TIMEOUT_EN` is not defined.

## Operation
The state machine has four states: `IDLE`, `ACCESS`, `DONE`, `ABORT`.

- **IDLE**
  - If `start` and (`is_load` or `is_store`): latch `address`, `store_data` and `we = !is_load`, then go to `ACCESS`.
  - If `start` is high with neither op bit set, it is ignored.
  - `mem_ack` in this state is ignored.
- **ACCESS**
  - `mem_req`=1. `mem_we`, `mem_addr` and `mem_wdata` are driven from the latched values and are held stable until ack.
  - On `mem_ack`: for a load, register `mem_rdata` into `mem_read`; then go to `DONE`.
  - Stores leave `mem_read` unchanged.
- **DONE**
  - `done`=1, `mem_req`=0, `stall`=0. Go to `IDLE`.
  - `start` in this cycle is not accepted; the pipeline re-presents the op.
- **ABORT** (only with the macro)
  - `err`=1, `done`=1, `mem_req`=0, `mem_read` = 32'h0. Go to `IDLE`.

Other rules:
- `stall` = (state==`IDLE` and `start` and a valid op) or state==`ACCESS`. It is combinational so the pipeline freezes in the same cycle as `start`.
- `mem_read` holds its value between loads. `address[1:0]` is discarded; no misalignment trap.

## Timing
- Reset values:
  - state = `IDLE`
  - `mem_req`, `mem_we`, `done`, `err`, `stall` = 0
  - `mem_addr`, `mem_wdata`, `mem_read` = 32'h0
- Reset assertion mid-transaction: the state returns to `IDLE` and `mem_req` drops immediately (asynchronously). The transaction is abandoned with no `done`.
- Latency: `start` accepted at cycle 0, `mem_req` is high from cycle 1. If `mem_ack` is sampled high at cycle k≥1, `done` and the new `mem_read` appear at cycle k+1. The minimum op-to-`done` latency is 2 cycles.
- Handshake:
  - `mem_req` stays high until the cycle in which `mem_ack` is sampled, inclusive, then drops.
  - Memory must not ack while `mem_req`=0. Such an ack is ignored.
- Back-to-back ops: the next `start` is accepted in `IDLE` at cycle k+2 at the earliest.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `ACCESS` and increments each `ACCESS` cycle without ack.
  - When the count equals `TIMEOUT_CYCLES` without ack, go to `ABORT`.
  - An ack in the same cycle the limit is reached wins, and the FSM goes to `DONE`.
- `MEM_TIMEOUT_EN` undefined:
  - No counter; `ACCESS` waits indefinitely.
  - `ABORT` does not exist and `err` is constant 0.

## Test plan
- **Reset state:** hold `rstn`=0 with random inputs → all outputs 0, `stall`=0.
- **Single load:** load at `address`=32'h0000_1007, ack at cycle 3 with `mem_rdata`=32'hCAFE_F00D → `mem_addr`=32'h0000_1004 and `mem_we`=0 for cycles 1-3, `done` at cycle 4, `mem_read`=32'hCAFE_F00D, `stall` high cycles 0-3.
- **Store:** store 32'h1234_5678 to 32'h20, ack in cycle 1 → `mem_we`=1, `mem_wdata`=32'h1234_5678, `done` at cycle 2, `mem_read` unchanged from the previous load.
- **Spurious and invalid inputs:** ack while `IDLE`, and `start` with `is_load`=`is_store`=0 → no `mem_req`, no `done`, `stall` stays 0.
- **Reset mid-op:** drop `rstn` at cycle 2 of an unacked load → `mem_req`=0 at once, no `done`; after release, a new load completes normally.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** load with no ack → `mem_req` high cycles 1-4, then `err`=`done`=1 for one cycle, `mem_read`=0; a separate run with ack at the 4th `ACCESS` cycle → normal `done`, `err`=0.
